mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single word-level RAM port between the cache manage unit (port 0) and a second bus master (port 1, e.g. uncached I/O / DMA). Each grant is held for a full burst so a cache block refill or write-back is never interleaved with foreign traffic. The arbiter sits between the requesters and the RAM controller. It routes request, address, write data and the ready handshake to and from the current owner.

## Interface
- BURST_LEN, 8: beats per burst. Must be a power of two, ≥2.
- ADDR_WIDTH, 30: word address width.
- DATA_WIDTH, 32: data width per beat.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p0_en / p1_en  in  1  port request. Held high for the whole burst.
- p0_write / p1_write  in  1  1 = write beat, 0 = read beat.
- p0_addr / p1_addr  in  ADDR_WIDTH  word address of the current beat. The requester advances it on each of its ready pulses.
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data of the current beat.
- p0_ready / p1_ready  out  1  beat-complete pulse for the owning port.
- p_rdata  out  DATA_WIDTH  mem_rdata broadcast to both ports. Valid only with that port's ready.
- mem_en  out  1  RAM request.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_ready  in  1  RAM beat-complete.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- arb_grant  out  2  one-hot owner: 01 = port 0, 10 = port 1, 00 = idle.

## Operation
- States (registered): IDLE, GRANT0, GRANT1.
- IDLE:
  - mem_en, mem_write, mem_addr and mem_wdata are driven to 0.
  - mem_ready is ignored and not forwarded.
  - If any pN_en is high, select an owner and move to GRANTn.
  - If only one port requests, that port wins.
  - If both request, the winner is set by the configuration (see Configuration).
- GRANTn:
  - mem_en/mem_write/mem_addr/mem_wdata = pN_* combinationally.
  - pN_ready = mem_ready & pN_en. The other port's ready is held at 0.
  - beat_cnt (log2(BURST_LEN) bits) increments on each forwarded ready.
- Release. Return to IDLE, clear beat_cnt and update last_grant when either:
  - a forwarded ready occurs with beat_cnt == BURST_LEN-1 (final beat), or
  - pN_en is sampled low (requester abort / short access).
  - A mem_ready arriving in the same cycle as pN_en low is not forwarded.
- Every release passes through IDLE for one cycle, so there is always one bubble between bursts.
- A non-owner request simply waits. The arbiter never drops or reorders a pending request.
- Reset (any time, including mid-burst):
  - state = IDLE, beat_cnt = 0, last_grant = port 1 (so port 0 wins the first tie).
  - All mem_* outputs, p0_ready, p1_ready and arb_grant are 0.
  - The RAM controller must tolerate the aborted burst.

## Timing
- Arbitration latency: request seen in IDLE at cycle t → mem_en high at t+1.
- Handshake path is zero-latency combinational: mem_ready → pN_ready. The requester updates its address and data on the clock edge that samples ready.
- Minimum burst occupancy: BURST_LEN + 1 cycles, including the IDLE bubble.
- The beat counter wraps modulo BURST_LEN and is forced to 0 on every release.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, grant the port opposite last_grant. This fairly alternates the ports under continuous contention.
- Not defined: fixed priority. Port 0 (cache) always wins a tie. last_grant is still maintained but unused; port 1 can starve.

## Structure
- Shared header arb_status.vh (included like status.vh) holds:
  - state encodings `ARB_IDLE / `ARB_GRANT0 / `ARB_GRANT1 (2-bit);
  - grant codes.
- One sub-module, arb_pick: combinational tie-break taking p0_en, p1_en and last_grant, and returning the one-hot winner. The ARB_ROUND_ROBIN_EN choice is confined to it.

## Test plan
- Port 0 alone, 8-beat read, mem_ready every cycle:
  - mem_en rises 1 cycle after p0_en;
  - 8 p0_ready pulses, p1_ready always 0;
  - arb_grant = 01, then 00 after beat 8.
- Both request in the same cycle with ARB_ROUND_ROBIN_EN: port 0 is granted first; port 1 is granted after exactly one IDLE cycle; a third simultaneous round grants port 0. Without the macro, port 0 wins every round.
- Port 1 requests during a port 0 burst at beat 3:
  - port 0 completes all 8 beats with no interleaving;
  - mem_addr never shows p1_addr until GRANT1.
- Port 0 drops p0_en after 2 beats: release to IDLE on the next edge, beat_cnt = 0, and pending port 1 is granted next.
- rst asserted asynchronously at beat 5 of a port 1 write: mem_en, mem_write, p1_ready and arb_grant are 0 immediately (before the next clock edge); after release a tie grants port 0.
- mem_ready stuck low for 20 cycles mid-burst: grant held, beat_cnt frozen, no ready pulses forwarded.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port burst arbiter mem_arbiter.
//
// Holds the 2-bit state encodings (`ARB_IDLE, `ARB_GRANT0, `ARB_GRANT1), the
// one-hot grant codes, the port identifiers used for last_grant, and a helper
// that maps a state to its one-hot arb_grant value.
//
// The macros are kept global so other blocks that report arbiter status can
// decode the same codes. The include guard allows them to be pulled in more
// than once.
`ifndef ARB_STATUS_DEFS
`define ARB_STATUS_DEFS
`define ARB_IDLE      2'b00
`define ARB_GRANT0    2'b01
`define ARB_GRANT1    2'b10
`define ARB_GNT_NONE  2'b00
`define ARB_GNT_P0    2'b01
`define ARB_GNT_P1    2'b10
`endif

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = `ARB_IDLE,
        ST_GRANT0 = `ARB_GRANT0,
        ST_GRANT1 = `ARB_GRANT1
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = `ARB_GNT_NONE;
    localparam logic [1:0] GNT_P0   = `ARB_GNT_P0;
    localparam logic [1:0] GNT_P1   = `ARB_GNT_P1;

    // Identifies the most recent owner. It feeds the round-robin tie-break.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Map an arbiter state onto its one-hot owner code.
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_IDLE:   g = GNT_NONE;
            ST_GRANT0: g = GNT_P0;
            ST_GRANT1: g = GNT_P1;
            default:   g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational choice of the next burst owner.
//
// Ports:
//   p0_en, p1_en  in   pending requests
//   last_grant    in   previous owner (PORT0 / PORT1)
//   winner        out  one-hot winner (GNT_P0 / GNT_P1 / GNT_NONE)
//
// Configuration macro ARB_ROUND_ROBIN_EN:
//   defined   - a tie goes to the port opposite last_grant
//   undefined - a tie always goes to port 0 (fixed priority)
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       p0_en,
    input  logic       p1_en,
    input  logic       last_grant,
    output logic [1:0] winner
);

`ifndef ARB_ROUND_ROBIN_EN
    // last_grant is tracked by the top but does not affect fixed priority.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Winner selection. A single requester always wins. Only a tie consults the policy.
    always_comb begin
        winner = GNT_NONE;
        if (p0_en && p1_en) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_grant == PORT0) begin
                winner = GNT_P1;
            end else begin
                winner = GNT_P0;
            end
`else
            winner = GNT_P0;
`endif
        end else if (p0_en) begin
            winner = GNT_P0;
        end else if (p1_en) begin
            winner = GNT_P1;
        end else begin
            winner = GNT_NONE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-level RAM port between port 0 (cache manage unit)
// and port 1 (uncached I/O / DMA). Ownership is held for a whole burst of
// BURST_LEN beats, or until the owner drops its request. Each release passes
// through IDLE for one cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pN_en/write/addr/wdata    requester N beat request (held for the burst)
//   pN_ready                  beat-complete pulse to the owning port
//   p_rdata                   mem_rdata broadcast to both ports
//   mem_en/write/addr/wdata   RAM request, routed from the current owner
//   mem_ready, mem_rdata      RAM beat-complete and read data
//   arb_grant                 one-hot owner (01 port 0, 10 port 1, 00 idle)
//
// Configuration macro ARB_ROUND_ROBIN_EN (used inside arb_pick) selects
// round-robin tie-breaking. By default port 0 has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_en,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ready,
    input  logic                  p1_en,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ready,
    output logic [DATA_WIDTH-1:0] p_rdata,
    output logic                  mem_en,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            arb_grant
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_r;
    arb_state_e       state_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] beat_cnt_s;
    logic             last_grant_r;
    logic             last_grant_s;
    logic [1:0]       winner_s;
    logic             own_en_s;
    logic             own_id_s;

    arb_pick u_pick (
        .p0_en      (p0_en),
        .p1_en      (p1_en),
        .last_grant (last_grant_r),
        .winner     (winner_s)
    );

    // Read data goes to both ports. Only the owner's ready qualifies it.
    assign p_rdata   = mem_rdata;
    assign arb_grant = grant_of(state_r);

    // State, beat counter and last owner registers. Reset makes port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            beat_cnt_r   <= CNT_ZERO;
            last_grant_r <= PORT1;
        end else begin
            state_r      <= state_s;
            beat_cnt_r   <= beat_cnt_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Owner routing, ready forwarding and next-state / release decision.
    always_comb begin
        state_s      = state_r;
        beat_cnt_s   = beat_cnt_r;
        last_grant_s = last_grant_r;
        mem_en       = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = {ADDR_WIDTH{1'b0}};
        mem_wdata    = {DATA_WIDTH{1'b0}};
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        own_en_s     = 1'b0;
        own_id_s     = PORT0;

        case (state_r)
            ST_IDLE: begin
                if (winner_s == GNT_P0) begin
                    state_s = ST_GRANT0;
                end else if (winner_s == GNT_P1) begin
                    state_s = ST_GRANT1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                mem_en    = p0_en;
                mem_write = p0_write;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
                p0_ready  = mem_ready & p0_en;
                own_en_s  = p0_en;
                own_id_s  = PORT0;
            end
            ST_GRANT1: begin
                mem_en    = p1_en;
                mem_write = p1_write;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
                p1_ready  = mem_ready & p1_en;
                own_en_s  = p1_en;
                own_id_s  = PORT1;
            end
            default: begin
                state_s    = ST_IDLE;
                beat_cnt_s = CNT_ZERO;
            end
        endcase

        // A dropped request wins over a same-cycle mem_ready. That beat is
        // not forwarded, and the burst ends here.
        if ((state_r == ST_GRANT0) || (state_r == ST_GRANT1)) begin
            if (!own_en_s || (mem_ready && (beat_cnt_r == LAST_BEAT))) begin
                state_s      = ST_IDLE;
                beat_cnt_s   = CNT_ZERO;
                last_grant_s = own_id_s;
            end else if (mem_ready) begin
                beat_cnt_s = beat_cnt_r + CNT_ONE;
            end else begin
                beat_cnt_s = beat_cnt_r;
            end
        end else begin
            last_grant_s = last_grant_r;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural owner/beat model is
// compared against the DUT outputs on every falling edge. Each directed
// scenario also checks literal, hand-derived expectations: grant order, gaps,
// beat counts and latency.
module tb_mem_arbiter;

    localparam int BL = 8;
    localparam int AW = 30;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_en = 1'b0, p0_write = 1'b0, p1_en = 1'b0, p1_write = 1'b0;
    logic [AW-1:0] p0_addr = 30'h100, p1_addr = 30'h2000;
    logic [DW-1:0] p0_wdata = 32'h0, p1_wdata = 32'h0, mem_rdata = 32'h0;
    logic          mem_ready = 1'b1;
    logic          p0_ready, p1_ready, mem_en, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, p_rdata;
    logic [1:0]    arb_grant;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_LEN(BL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_en(p0_en), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ready(p0_ready),
        .p1_en(p1_en), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ready(p1_ready),
        .p_rdata(p_rdata), .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .arb_grant(arb_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner is -1 (idle), 0 or 1. beats counts completed beats of the burst.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_beats <= 0;
            m_last  <= 1;
        end else if (m_owner < 0) begin
            if (p0_en && p1_en) m_owner <= RR ? (1 - m_last) : 0;
            else if (p0_en)     m_owner <= 0;
            else if (p1_en)     m_owner <= 1;
        end else if (!((m_owner == 0) ? p0_en : p1_en)) begin
            m_last  <= m_owner;
            m_owner <= -1;
            m_beats <= 0;
        end else if (mem_ready) begin
            if (m_beats + 1 == BL) begin
                m_last  <= m_owner;
                m_owner <= -1;
                m_beats <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    // Compare process: the DUT must route exactly the model's owner.
    always @(negedge clk) begin
        chk("arb_grant", arb_grant, (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00));
        chk("mem_en", mem_en, (m_owner == 0) ? p0_en : ((m_owner == 1) ? p1_en : 1'b0));
        chk("mem_write", mem_write, (m_owner == 0) ? p0_write : ((m_owner == 1) ? p1_write : 1'b0));
        chk("mem_addr", mem_addr, (m_owner == 0) ? p0_addr : ((m_owner == 1) ? p1_addr : {AW{1'b0}}));
        chk("mem_wdata", mem_wdata, (m_owner == 0) ? p0_wdata : ((m_owner == 1) ? p1_wdata : {DW{1'b0}}));
        chk("p0_ready", p0_ready, (m_owner == 0) && p0_en && mem_ready);
        chk("p1_ready", p1_ready, (m_owner == 1) && p1_en && mem_ready);
        chk("p_rdata", p_rdata, mem_rdata);
    end

    // Requester and stimulus state (owned by the main initial block).
    int   q0[$], q1[$];
    int   rem0 = 0, rem1 = 0;
    logic rdy_next = 1'b1, wr0_next = 1'b0, wr1_next = 1'b0;
    logic cap_rdy0 = 1'b0, cap_rdy1 = 1'b0, cap_mem_en = 1'b0;
    logic [1:0] cap_grant = 2'b00;
    int   rdy_cnt0 = 0, rdy_cnt1 = 0, idle_run = 0;
    int   grant_order[$], gap_log[$];
    bit   addr_leak = 1'b0;

    // One clock: requesters react to the ready they saw, then observe at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (p0_en && cap_rdy0) begin
            p0_addr  = p0_addr + 30'd1;
            p0_wdata = $urandom;
            rem0--;
            if (rem0 == 0) begin
                if (q0.size() > 0) rem0 = q0.pop_front();
                else p0_en = 1'b0;
            end
        end else if (!p0_en && q0.size() > 0) begin
            rem0  = q0.pop_front();
            p0_en = 1'b1;
        end
        if (p1_en && cap_rdy1) begin
            p1_addr  = p1_addr + 30'd1;
            p1_wdata = $urandom;
            rem1--;
            if (rem1 == 0) begin
                if (q1.size() > 0) rem1 = q1.pop_front();
                else p1_en = 1'b0;
            end
        end else if (!p1_en && q1.size() > 0) begin
            rem1  = q1.pop_front();
            p1_en = 1'b1;
        end
        mem_ready = rdy_next;
        p0_write  = wr0_next;
        p1_write  = wr1_next;
        mem_rdata = $urandom;
        @(negedge clk);
        cap_rdy0   = p0_ready;
        cap_rdy1   = p1_ready;
        cap_mem_en = mem_en;
        rdy_cnt0  += int'(p0_ready);
        rdy_cnt1  += int'(p1_ready);
        if (arb_grant != 2'b00 && cap_grant == 2'b00) begin
            grant_order.push_back((arb_grant == 2'b01) ? 0 : 1);
            gap_log.push_back(idle_run);
            idle_run = 0;
        end
        if (arb_grant == 2'b00) idle_run++;
        if (arb_grant == 2'b01 && mem_addr == p1_addr) addr_leak = 1'b1;
        cap_grant = arb_grant;
    endtask

    task automatic clr_stats();
        rdy_cnt0 = 0; rdy_cnt1 = 0; idle_run = 0; addr_leak = 1'b0;
        grant_order.delete();
        gap_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while ((p0_en || p1_en || q0.size() > 0 || q1.size() > 0 || cap_grant != 2'b00) && n < 300);
        chk({name, "_done_in_time"}, (n < 300), 1'b1);
    endtask

    task automatic step_until_rdy(input int port, input int count);
        int n = 0;
        while (((port == 0) ? rdy_cnt0 : rdy_cnt1) < count && n < 100) begin
            step();
            n++;
        end
        chk("beat_wait_in_time", (n < 100), 1'b1);
    endtask

    initial begin
        int lat;
        int held;
        // Reset state
        #2 rst = 1'b1;
        step(); step();
        chk("rst_grant", arb_grant, 2'b00);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_ready", {p0_ready, p1_ready}, 2'b00);
        #2 rst = 1'b0;

        // Port 0 alone, 8-beat read
        clr_stats();
        q0.push_back(8);
        step();
        chk("s1_mem_en_same_cycle", cap_mem_en, 1'b0);
        lat = 0;
        do begin step(); lat++; end while (!cap_mem_en && lat < 10);
        chk("s1_latency", lat, 1);
        chk("s1_grant", cap_grant, 2'b01);
        wait_idle("s1");
        chk("s1_p0_beats", rdy_cnt0, 8);
        chk("s1_p1_beats", rdy_cnt1, 0);

        // Simultaneous requests, port 0 re-requests back to back
        clr_stats();
        q0.push_back(8); q0.push_back(8); q1.push_back(8);
        wait_idle("s2");
        chk("s2_n_grants", grant_order.size(), 3);
        if (grant_order.size() == 3 && gap_log.size() == 3) begin
            chk("s2_first", grant_order[0], 0);
            chk("s2_second", grant_order[1], RR ? 1 : 0);
            chk("s2_third", grant_order[2], RR ? 0 : 1);
            chk("s2_gap1", gap_log[1], 1);
            chk("s2_gap2", gap_log[2], 1);
        end
        chk("s2_p0_beats", rdy_cnt0, 16);
        chk("s2_p1_beats", rdy_cnt1, 8);

        // Port 1 arrives at beat 3 of a port 0 write burst
        clr_stats();
        wr0_next = 1'b1;
        q0.push_back(8);
        step_until_rdy(0, 3);
        q1.push_back(8);
        wait_idle("s3");
        chk("s3_n_grants", grant_order.size(), 2);
        if (grant_order.size() == 2) begin
            chk("s3_order", {grant_order[0][1:0], grant_order[1][1:0]}, 4'b0001);
            chk("s3_gap", gap_log[1], 1);
        end
        chk("s3_no_p1_addr_leak", addr_leak, 1'b0);
        chk("s3_p0_beats", rdy_cnt0, 8);
        chk("s3_p1_beats", rdy_cnt1, 8);
        wr0_next = 1'b0;

        // Port 0 aborts after 2 beats, port 1 pending
        clr_stats();
        q0.push_back(2);
        step_until_rdy(0, 1);
        q1.push_back(8);
        wait_idle("s4");
        chk("s4_p0_beats", rdy_cnt0, 2);
        chk("s4_p1_beats", rdy_cnt1, 8);
        chk("s4_n_grants", grant_order.size(), 2);
        if (grant_order.size() == 2) begin
            chk("s4_next_owner", grant_order[1], 1);
            chk("s4_gap", gap_log[1], 1);
        end

        // Asynchronous reset at beat 5 of a port 1 write
        clr_stats();
        wr1_next = 1'b1;
        q1.push_back(8);
        step_until_rdy(1, 5);
        chk("s5_pre_mem_en", mem_en, 1'b1);
        chk("s5_pre_p1_ready", p1_ready, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("s5_async_mem_en", mem_en, 1'b0);
        chk("s5_async_mem_write", mem_write, 1'b0);
        chk("s5_async_p1_ready", p1_ready, 1'b0);
        chk("s5_async_grant", arb_grant, 2'b00);
        p1_en = 1'b0; rem1 = 0; q1.delete(); cap_rdy1 = 1'b0;
        wr1_next = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        clr_stats();
        q0.push_back(8); q1.push_back(8);
        wait_idle("s5");
        chk("s5_n_grants", grant_order.size(), 2);
        if (grant_order.size() == 2) chk("s5_tie_after_reset", grant_order[0], 0);

        // mem_ready stuck low for 20 cycles mid-burst
        clr_stats();
        q0.push_back(8);
        step_until_rdy(0, 3);
        rdy_next = 1'b0;
        step();
        held = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cap_grant == 2'b01) held++;
        end
        chk("s6_grant_held", held, 20);
        chk("s6_frozen_beats", rdy_cnt0, 3);
        rdy_next = 1'b1;
        wait_idle("s6");
        chk("s6_total_beats", rdy_cnt0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
